// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: step-sequencer state encoding
// and the default step-index width.
package cpu_ctrl_pkg;

  localparam int SEL_WIDTH_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : cpu_ctrl_pkg

// File: rtl/onehot_decoder.sv
// Purely combinational index to one-hot map (N to 2^N), used on the
// sequencer's next-state count so the strobe can be registered.
module onehot_decoder #(
  parameter int SEL_WIDTH = 4
) (
  input  logic [SEL_WIDTH-1:0]      i_sel,
  output logic [(2**SEL_WIDTH)-1:0] o_onehot
);

  always_comb begin
    // NOTE: assign a default before any selective write so no latch is inferred.
    o_onehot        = '0;
    o_onehot[i_sel] = 1'b1;
  end

endmodule : onehot_decoder

// File: rtl/control_step_sequencer.sv
// Control-step generator: step counter plus one-hot decode, giving registered
// glitch-free T0..T(2^N-1) strobes with stall, branch and abort controls.
module control_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int SEL_WIDTH = SEL_WIDTH_DEFAULT,
  // Derived from SEL_WIDTH; leave at its default.
  parameter int OUT_WIDTH = 2**SEL_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 advance,
  input  logic                 abort,
  input  logic                 load,
  input  logic [SEL_WIDTH-1:0] loadStep,
  input  logic [SEL_WIDTH-1:0] lastStep,
  output logic [OUT_WIDTH-1:0] stepOutput,
  output logic [SEL_WIDTH-1:0] stepCount,
  output logic                 active,
  output logic                 done
);

  state_t               r_state;
  logic [SEL_WIDTH-1:0] r_count;
  logic [SEL_WIDTH-1:0] r_last;
  logic [OUT_WIDTH-1:0] r_step_out;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [SEL_WIDTH-1:0] w_count_nxt;
  logic [SEL_WIDTH-1:0] w_last_nxt;
  logic                 w_done_nxt;
  logic [OUT_WIDTH-1:0] w_onehot;
  logic [OUT_WIDTH-1:0] w_step_out_nxt;
  logic                 w_complete;

  // Completion is the final step being advanced past while running.
  assign w_complete = (r_state == ST_RUN) && advance && (r_count == r_last);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;

    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else if (load) begin
      w_state_nxt = ST_RUN;
      w_count_nxt = loadStep;
      if (r_state == ST_IDLE) w_last_nxt = lastStep;
    end else if (start) begin
      // A restart on the completing cycle still reports the completion.
      w_state_nxt = ST_RUN;
      w_count_nxt = '0;
      w_last_nxt  = lastStep;
      w_done_nxt  = w_complete;
    end else if (w_complete) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
      w_done_nxt  = 1'b1;
    end else if ((r_state == ST_RUN) && advance) begin
      w_count_nxt = r_count + 1'b1;
    end
  end

  onehot_decoder #(
    .SEL_WIDTH (SEL_WIDTH)
  ) u_decoder (
    .i_sel    (w_count_nxt),
    .o_onehot (w_onehot)
  );

  assign w_step_out_nxt = (w_state_nxt == ST_RUN) ? w_onehot : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_last     <= '0;
      r_step_out <= '0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_last     <= w_last_nxt;
      r_step_out <= w_step_out_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign stepOutput = r_step_out;
  assign stepCount  = r_count;
  assign active     = (r_state == ST_RUN);
  assign done       = r_done;

endmodule : control_step_sequencer

// File: tb/tb_control_step_sequencer.sv
// Directed self-checking bench for control_step_sequencer (default width and
// a SEL_WIDTH=3 build), with hand-computed expected strobes.
module tb_control_step_sequencer;

  logic        clock;
  logic        reset;
  logic        start, advance, abort, load;
  logic [3:0]  loadStep, lastStep;
  logic [15:0] stepOutput;
  logic [3:0]  stepCount;
  logic        active, done;

  logic        s3_start, s3_advance, s3_abort, s3_load;
  logic [2:0]  s3_loadStep, s3_lastStep;
  logic [7:0]  s3_stepOutput;
  logic [2:0]  s3_stepCount;
  logic        s3_active, s3_done;

  int n_checks = 0;
  int n_errors = 0;

  control_step_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .advance    (advance),
    .abort      (abort),
    .load       (load),
    .loadStep   (loadStep),
    .lastStep   (lastStep),
    .stepOutput (stepOutput),
    .stepCount  (stepCount),
    .active     (active),
    .done       (done)
  );

  control_step_sequencer #(.SEL_WIDTH(3)) dut3 (
    .clock      (clock),
    .reset      (reset),
    .start      (s3_start),
    .advance    (s3_advance),
    .abort      (s3_abort),
    .load       (s3_load),
    .loadStep   (s3_loadStep),
    .lastStep   (s3_lastStep),
    .stepOutput (s3_stepOutput),
    .stepCount  (s3_stepCount),
    .active     (s3_active),
    .done       (s3_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [15:0] so, input logic [3:0] cnt,
                            input logic act, input logic dn);
    check({tag, ".out"},    32'(stepOutput), 32'(so));
    check({tag, ".count"},  32'(stepCount),  32'(cnt));
    check({tag, ".active"}, 32'(active),     32'(act));
    check({tag, ".done"},   32'(done),       32'(dn));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; advance = 1'b0; abort = 1'b0; load = 1'b0;
    loadStep = '0; lastStep = '0;
  endtask

  initial begin
    clear_inputs();
    s3_start = 1'b0; s3_advance = 1'b0; s3_abort = 1'b0; s3_load = 1'b0;
    s3_loadStep = '0; s3_lastStep = '0;
    reset = 1'b1;
    #12;
    expect_all("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Basic run, lastStep=3
    start = 1'b1; lastStep = 4'd3; advance = 1'b1;
    tick(); expect_all("run.t0", 16'h0001, 4'd0, 1'b1, 1'b0);
    start = 1'b0; lastStep = 4'd0;
    tick(); expect_all("run.t1", 16'h0002, 4'd1, 1'b1, 1'b0);
    tick(); expect_all("run.t2", 16'h0004, 4'd2, 1'b1, 1'b0);
    tick(); expect_all("run.t3", 16'h0008, 4'd3, 1'b1, 1'b0);
    tick(); expect_all("run.done", 16'h0000, 4'd0, 1'b0, 1'b1);
    tick(); expect_all("run.idle", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Stall at T2
    clear_inputs();
    start = 1'b1; lastStep = 4'd5;
    tick(); expect_all("stall.t0", 16'h0001, 4'd0, 1'b1, 1'b0);
    start = 1'b0; advance = 1'b1;
    tick(); tick(); expect_all("stall.t2", 16'h0004, 4'd2, 1'b1, 1'b0);
    advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_all($sformatf("stall.hold%0d", i), 16'h0004, 4'd2, 1'b1, 1'b0);
    end
    advance = 1'b1;
    tick(); expect_all("stall.resume", 16'h0008, 4'd3, 1'b1, 1'b0);
    advance = 1'b0; abort = 1'b1;
    tick(); expect_all("stall.abort", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Branch forward within the sequence
    clear_inputs();
    start = 1'b1; lastStep = 4'd7;
    tick(); start = 1'b0; advance = 1'b1;
    tick(); expect_all("br.t1", 16'h0002, 4'd1, 1'b1, 1'b0);
    load = 1'b1; loadStep = 4'd6;
    tick(); expect_all("br.t6", 16'h0040, 4'd6, 1'b1, 1'b0);
    load = 1'b0;
    tick(); expect_all("br.t7", 16'h0080, 4'd7, 1'b1, 1'b0);
    tick(); expect_all("br.done", 16'h0000, 4'd0, 1'b0, 1'b1);

    // Branch past lastReg: wraps through 15 -> 0 before completing at 7
    clear_inputs();
    start = 1'b1; lastStep = 4'd7;
    tick(); start = 1'b0;
    load = 1'b1; loadStep = 4'd9;
    tick(); expect_all("skip.t9", 16'h0200, 4'd9, 1'b1, 1'b0);
    load = 1'b0; advance = 1'b1;
    for (int k = 10; k < 16; k++) begin
      tick(); expect_all($sformatf("skip.t%0d", k), 16'(1 << k), 4'(k), 1'b1, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      tick(); expect_all($sformatf("skip.w%0d", k), 16'(1 << k), 4'(k), 1'b1, 1'b0);
    end
    tick(); expect_all("skip.done", 16'h0000, 4'd0, 1'b0, 1'b1);

    // abort + load + start together: abort wins
    clear_inputs();
    start = 1'b1; lastStep = 4'd3;
    tick(); expect_all("sim.t0", 16'h0001, 4'd0, 1'b1, 1'b0);
    abort = 1'b1; load = 1'b1; loadStep = 4'd5;
    tick(); expect_all("sim.abort", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Completion coinciding with start
    clear_inputs();
    start = 1'b1; lastStep = 4'd1;
    tick(); start = 1'b0; advance = 1'b1;
    tick(); expect_all("cs.t1", 16'h0002, 4'd1, 1'b1, 1'b0);
    start = 1'b1; lastStep = 4'd2;
    tick(); expect_all("cs.restart", 16'h0001, 4'd0, 1'b1, 1'b1);
    start = 1'b0; advance = 1'b0;
    tick(); expect_all("cs.hold", 16'h0001, 4'd0, 1'b1, 1'b0);
    abort = 1'b1;
    tick(); abort = 1'b0;

    // load from IDLE latches lastStep
    clear_inputs();
    load = 1'b1; loadStep = 4'd2; lastStep = 4'd3;
    tick(); expect_all("ldi.t2", 16'h0004, 4'd2, 1'b1, 1'b0);
    load = 1'b0; lastStep = 4'd0; advance = 1'b1;
    tick(); expect_all("ldi.t3", 16'h0008, 4'd3, 1'b1, 1'b0);
    tick(); expect_all("ldi.done", 16'h0000, 4'd0, 1'b0, 1'b1);

    // Asynchronous reset at T5
    clear_inputs();
    start = 1'b1; lastStep = 4'd9;
    tick(); start = 1'b0; advance = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    expect_all("ar.t5", 16'h0020, 4'd5, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 expect_all("ar.async", 16'h0000, 4'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    tick(); expect_all("ar.adv_idle", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick(); expect_all("ar.adv_idle2", 16'h0000, 4'd0, 1'b0, 1'b0);
    clear_inputs();

    // SEL_WIDTH=3 build, lastStep=7
    s3_start = 1'b1; s3_lastStep = 3'd7; s3_advance = 1'b1;
    tick();
    s3_start = 1'b0;
    check("w3.t0.out", 32'(s3_stepOutput), 32'h01);
    check("w3.t0.active", 32'(s3_active), 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("w3.t%0d.out", k), 32'(s3_stepOutput), 32'(1 << k));
      check($sformatf("w3.t%0d.count", k), 32'(s3_stepCount), 32'(k));
      check($sformatf("w3.t%0d.done", k), 32'(s3_done), 32'd0);
    end
    tick();
    check("w3.done.out", 32'(s3_stepOutput), 32'h00);
    check("w3.done.done", 32'(s3_done), 32'd1);
    check("w3.done.active", 32'(s3_active), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_control_step_sequencer
